// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   Multi-channel PWM generator with a shared prescaler and period counter.
//   Each channel has a shadow duty register (written over the wr_* port)
//   and an active duty register that is reloaded from the shadow at every
//   period wrap, so duty changes never produce a glitched period.
//
//   Optional feature macro: PWM_CENTER_ALIGNED_EN
//     undefined : edge-aligned counter 0..MAX, wrap on MAX->0
//     defined   : centre-aligned counter 0..MAX..1, wrap on 1->0 going down
module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 12,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [NUM_CH-1:0] out_en,
  input  logic [NUM_CH-1:0] pwm_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  // Channel count widened by one bit so NUM_CH == 2^ADDR_W still fits.
  localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W+1)'(NUM_CH);

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  logic addr_in_range;
  logic wr_accept;
  logic wr_reject;

  assign addr_in_range = ({1'b0, wr_addr} < NUM_CH_EXT);
  assign wr_accept     = wr_valid &&  addr_in_range;
  assign wr_reject     = wr_valid && !addr_in_range;

  // Write handshake: one-cycle acknowledge or error pulse after each write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_accept;
      wr_err <= wr_reject;
    end
  end

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] presc_reg;
  logic [DIV_W-1:0] presc_next;
  logic             tick;

  // Using >= (not ==) lets a freshly lowered clk_div recover in one clock
  // instead of running the counter all the way round.
  assign tick       = (presc_reg >= clk_div);
  assign presc_next = tick ? '0 : presc_reg + DIV_W'(1);

  // Prescaler count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  // ---------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap;

`ifdef PWM_CENTER_ALIGNED_EN
  logic dir_down_reg;
  logic dir_down_next;

  // Wrap is the 1->0 step of the down slope; MAX is a turning point only.
  assign wrap = tick && dir_down_reg && (cnt_reg == CNT_ONE);

  // Up/down counter next-state
  always_comb begin
    cnt_next      = cnt_reg;
    dir_down_next = dir_down_reg;
    if (tick) begin
      if (!dir_down_reg) begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next      = CNT_MAX - CNT_ONE;
          dir_down_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end else begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          dir_down_next = 1'b0;
        end
      end
    end
  end

  // Counter direction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_down_reg <= 1'b0;
    end else begin
      dir_down_reg <= dir_down_next;
    end
  end
`else
  // Edge-aligned: natural binary rollover from MAX back to 0.
  assign wrap     = tick && (cnt_reg == CNT_MAX);
  assign cnt_next = tick ? cnt_reg + CNT_ONE : cnt_reg;
`endif

  // Period counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Period start flag, aligned with the cycle in which cnt shows 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel duty registers and compare
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] pwm_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] shadow_reg;
      logic [CNT_W-1:0] active_reg;
      logic             wr_hit;
      logic             cmp_high;

      assign wr_hit = wr_accept && (wr_addr == ADDR_W'(gi));

      // Shadow duty: host-visible copy, updated by accepted writes
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg <= '0;
        end else if (wr_hit) begin
          shadow_reg <= wr_data;
        end
      end

      // Active duty: reloaded only at a wrap; sees the pre-write shadow
      // when a write lands in the wrap cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          active_reg <= '0;
        end else if (wrap) begin
          active_reg <= shadow_reg;
        end
      end

      // Full-scale duty is forced high so MAX really means 100 %.
      assign cmp_high     = (active_reg == CNT_MAX) || (cnt_reg < active_reg);
      assign pwm_next[gi] = out_en[gi] && (!pwm_en[gi] || cmp_high);
    end
  endgenerate

  // Output pins are registered to keep them glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_next;
    end
  end

endmodule
